dot_product_row_feeder: RTL and testbench

Producer side of the dot-product row handshake. On a start pulse it fetches operand packages of `no_of_units` elements from two row memories, presents them one at a time with a one-cycle `outsider_read_now` strobe, and waits for `I_am_ready` before fetching the next. After the last package it waits for the dot-product unit's `finish`, captures the scalar result and reports it upstream. It sits between the row/vector memories and the eight-unit dot-product datapath, and owns that datapath's reset.

---
 rtl/dot_product_row_feeder_if.sv | 43 ++++
 rtl/dot_product_row_feeder.sv | 142 ++++++++++++++
 tb/tb_dot_product_row_feeder.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_row_feeder_if.sv
// Signal bundle between the row feeder and its neighbours: job issuer, row memories, dot-product unit.
// The feeder uses the master modport; the surrounding system uses slave.
interface dot_product_row_feeder_if #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 10
);
  localparam int row_width = element_width * no_of_units;

  logic                     start;
  logic [31:0]              total;
  logic [addr_width-1:0]    a_base;
  logic [addr_width-1:0]    b_base;
  logic [addr_width-1:0]    a_addr;
  logic [addr_width-1:0]    b_addr;
  logic                     mem_rd_en;
  logic [row_width-1:0]     a_data;
  logic [row_width-1:0]     b_data;
  logic [row_width-1:0]     first_row_output;
  logic [row_width-1:0]     second_row_output;
  logic                     outsider_read_now;
  logic [31:0]              total_out;
  logic                     dp_reset;
  logic                     I_am_ready;
  logic                     finish;
  logic [element_width-1:0] dot_product_input;
  logic [element_width-1:0] result;
  logic                     result_valid;
  logic                     busy;
  logic                     error;

  modport master (
    input  start, total, a_base, b_base, a_data, b_data, I_am_ready, finish, dot_product_input,
    output a_addr, b_addr, mem_rd_en, first_row_output, second_row_output, outsider_read_now,
           total_out, dp_reset, result, result_valid, busy, error
  );

  modport slave (
    output start, total, a_base, b_base, a_data, b_data, I_am_ready, finish, dot_product_input,
    input  a_addr, b_addr, mem_rd_en, first_row_output, second_row_output, outsider_read_now,
           total_out, dp_reset, result, result_valid, busy, error
  );
endinterface

// File: rtl/dot_product_row_feeder.sv
// Fetches operand packages from two row memories, hands them one by one to the dot-product unit,
// then waits for its finish edge and captures the scalar result. Owns the unit's reset.
module dot_product_row_feeder #(
  parameter int element_width  = 32,
  parameter int no_of_units    = 8,
  parameter int addr_width     = 10,
  parameter int timeout_cycles = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  dot_product_row_feeder_if.master bus
);
  localparam int row_width = element_width * no_of_units;
  localparam int wd_width  = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    IDLE, DPRST, FETCH, LOAD, PRESENT, WAIT_READY, WAIT_FINISH
  } state_t;

  state_t                   state, state_next;
  logic [31:0]              total_q;
  logic [31:0]              pkg_cnt;
  logic [31:0]              last_pkg;
  logic [addr_width-1:0]    a_base_q, b_base_q;
  logic [row_width-1:0]     a_row, b_row;
  logic [element_width-1:0] result_q;
  logic [wd_width-1:0]      wd_cnt;
  logic                     dprst_second;
  logic                     finish_q;
  logic                     dp_reset_q;
  logic                     error_q;
  logic                     result_valid_q;
  logic                     total_ok;
  logic                     finish_rise;
  logic                     timeout;

  assign total_ok    = (bus.total != 32'd0) && ((bus.total % 32'(no_of_units)) == 32'd0);
  assign last_pkg    = (total_q / 32'(no_of_units)) - 32'd1;
  assign finish_rise = bus.finish && !finish_q;
  assign timeout     = (wd_cnt == wd_width'(timeout_cycles - 1)) &&
                       ((state == WAIT_READY && !bus.I_am_ready) ||
                        (state == WAIT_FINISH && !finish_rise));

  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:        if (bus.start && total_ok) state_next = DPRST;
      DPRST:       if (dprst_second) state_next = FETCH;
      FETCH:       state_next = LOAD;
      LOAD:        state_next = PRESENT;
      PRESENT:     state_next = WAIT_READY;
      WAIT_READY: begin
        if (bus.I_am_ready)  state_next = (pkg_cnt == last_pkg) ? WAIT_FINISH : FETCH;
        else if (timeout)    state_next = IDLE;
      end
      WAIT_FINISH: if (finish_rise || timeout) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // NOTE: all state here updates with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: row and result registers are reset too: the dot-product unit sees zeros, never stale data.
      state          <= IDLE;
      total_q        <= '0;
      pkg_cnt        <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
      a_row          <= '0;
      b_row          <= '0;
      result_q       <= '0;
      wd_cnt         <= '0;
      dprst_second   <= 1'b0;
      finish_q       <= 1'b0;
      dp_reset_q     <= 1'b1;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_next;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      dp_reset_q     <= 1'b0;
      dprst_second   <= (state == DPRST) ? !dprst_second : 1'b0;
      // Edge history restarts with each job so a level left high by the last job cannot count as new.
      finish_q       <= (state == DPRST) ? 1'b0 : bus.finish;

      if ((state == WAIT_READY || state == WAIT_FINISH) && state_next == state)
        wd_cnt <= wd_cnt + wd_width'(1);
      else
        wd_cnt <= '0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (total_ok) begin
              total_q  <= bus.total;
              a_base_q <= bus.a_base;
              b_base_q <= bus.b_base;
              pkg_cnt  <= '0;
            end else begin
              error_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          a_row <= bus.a_data;
          b_row <= bus.b_data;
        end
        WAIT_READY: begin
          if (bus.I_am_ready && pkg_cnt != last_pkg) pkg_cnt <= pkg_cnt + 32'd1;
        end
        WAIT_FINISH: begin
          if (finish_rise) begin
            result_q       <= bus.dot_product_input;
            result_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if (timeout) begin
        error_q    <= 1'b1;
        dp_reset_q <= 1'b1;
      end
    end
  end

  assign bus.mem_rd_en         = (state == FETCH);
  assign bus.a_addr            = (state == FETCH) ? a_base_q + pkg_cnt[addr_width-1:0] : '0;
  assign bus.b_addr            = (state == FETCH) ? b_base_q + pkg_cnt[addr_width-1:0] : '0;
  assign bus.first_row_output  = a_row;
  assign bus.second_row_output = b_row;
  assign bus.outsider_read_now = (state == PRESENT);
  assign bus.total_out         = total_q;
  assign bus.dp_reset          = dp_reset_q || (state == DPRST);
  assign bus.result            = result_q;
  assign bus.result_valid      = result_valid_q;
  assign bus.busy              = (state != IDLE);
  assign bus.error             = error_q;
endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Bench for dot_product_row_feeder: behavioural row memories, a package/result scoreboard,
// and one task per scenario. Outputs are sampled 1 ns after the falling edge.
module tb_dot_product_row_feeder;
  localparam int ew  = 32;
  localparam int nu  = 8;
  localparam int aw  = 10;
  localparam int tmo = 256;
  localparam int rw  = ew * nu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_product_row_feeder_if #(.element_width(ew), .no_of_units(nu), .addr_width(aw)) bus ();

  dot_product_row_feeder #(
    .element_width(ew), .no_of_units(nu), .addr_width(aw), .timeout_cycles(tmo)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [aw-1:0] a_addr;
    logic [aw-1:0] b_addr;
    logic [rw-1:0] a_row;
    logic [rw-1:0] b_row;
  } pkg_t;

  pkg_t          exp_q[$];
  logic [ew-1:0] res_q[$];
  logic [31:0]   exp_total;
  int            total_checks = 0;
  int            bad = 0;
  int            rv_cnt = 0, err_cnt = 0, rd_cnt = 0, strobe_cnt = 0;

  // Every element encodes its memory tag, package address and lane.
  function automatic logic [rw-1:0] pkg_data(input logic [aw-1:0] addr, input logic [7:0] tag);
    logic [rw-1:0] d;
    for (int e = 0; e < nu; e++) d[e*ew +: ew] = {tag, 6'd0, addr, 8'(e)};
    return d;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.a_data <= pkg_data(bus.a_addr, 8'hA0);
      bus.b_data <= pkg_data(bus.b_addr, 8'hB0);
    end
  end

  always @(negedge clk) begin
    if (bus.result_valid)      rv_cnt++;
    if (bus.error)             err_cnt++;
    if (bus.mem_rd_en)         rd_cnt++;
    if (bus.outsider_read_now) strobe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  // One-cycle pulses on start and I_am_ready end at the next tick.
  task automatic tick();
    @(negedge clk);
    #1;
    bus.start      = 1'b0;
    bus.I_am_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    logic [600:0] v;
    v = {bus.busy, bus.mem_rd_en, bus.outsider_read_now, bus.result_valid, bus.error,
         bus.a_addr, bus.b_addr, bus.total_out, bus.result, bus.first_row_output, bus.second_row_output};
    total_checks++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s: outputs=%h required all zero", name, v);
    end
    total_checks++;
    if (bus.dp_reset !== 1'b1) begin
      bad++;
      $display("FAIL %s_dp_reset: got %b required 1", name, bus.dp_reset);
    end
  endtask

  task automatic start_job(input logic [31:0] tot, input logic [aw-1:0] ab, input logic [aw-1:0] bb);
    pkg_t p;
    for (int k = 0; k < int'(tot / nu); k++) begin
      p.a_addr = ab + aw'(k);
      p.b_addr = bb + aw'(k);
      p.a_row  = pkg_data(p.a_addr, 8'hA0);
      p.b_row  = pkg_data(p.b_addr, 8'hB0);
      exp_q.push_back(p);
    end
    exp_total  = tot;
    bus.total  = tot;
    bus.a_base = ab;
    bus.b_base = bb;
    bus.start  = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      total_checks++;
      if ({bus.busy, bus.dp_reset} !== 2'b11) begin
        bad++;
        $display("FAIL dprst_cycle%0d: busy,dp_reset=%b required 11", c, {bus.busy, bus.dp_reset});
      end
    end
  endtask

  // Waits for the next strobe (3 cycles from the reference point), checks address and rows,
  // holds for lat cycles, then pulses I_am_ready (or pulls reset when abort is set).
  task automatic serve_pkg(input int lat, input bit early, input bit abort);
    pkg_t p;
    int   n;
    bit   seen;
    if (exp_q.size() == 0) begin
      bad++;
      total_checks++;
      $display("FAIL scoreboard_empty: no package expected, required at least one");
      return;
    end
    p    = exp_q[0];
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.mem_rd_en) begin
        total_checks++;
        if ({bus.a_addr, bus.b_addr} !== {p.a_addr, p.b_addr}) begin
          bad++;
          $display("FAIL fetch_addr: a=%h b=%h required a=%h b=%h", bus.a_addr, bus.b_addr, p.a_addr, p.b_addr);
        end
      end
      if (bus.outsider_read_now) seen = 1'b1;
    end
    total_checks++;
    if (!seen || n != 3) begin
      bad++;
      $display("FAIL strobe_gap: seen=%b after %0d cycles required 3", seen, n);
    end
    if (!seen) return;
    p = exp_q.pop_front();
    total_checks++;
    if ({bus.first_row_output, bus.second_row_output} !== {p.a_row, p.b_row}) begin
      bad++;
      $display("FAIL rows: a=%h required %h", bus.first_row_output, p.a_row);
    end
    total_checks++;
    if (bus.total_out !== exp_total) begin
      bad++;
      $display("FAIL total_out: got %0d required %0d", bus.total_out, exp_total);
    end
    if (early) bus.I_am_ready = 1'b1;
    if (abort) begin
      tick();
      reset = 1'b0;
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      tick();
      total_checks++;
      if ({bus.first_row_output, bus.second_row_output, bus.outsider_read_now} !== {p.a_row, p.b_row, 1'b0}) begin
        bad++;
        $display("FAIL rows_hold_%0d: strobe=%b a=%h required strobe=0 a=%h",
                 i, bus.outsider_read_now, bus.first_row_output, p.a_row);
      end
    end
    bus.I_am_ready = 1'b1;
  endtask

  task automatic finish_job(input int dly, input logic [ew-1:0] val, input bit keep_high);
    int            rv0;
    logic [ew-1:0] want;
    repeat (dly) tick();
    rv0                   = rv_cnt;
    bus.dot_product_input = val;
    bus.finish            = 1'b1;
    res_q.push_back(val);
    tick();
    want = res_q.pop_front();
    total_checks++;
    if ({bus.result_valid, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL capture_flags: result_valid,busy=%b required 10", {bus.result_valid, bus.busy});
    end
    total_checks++;
    if (bus.result !== want) begin
      bad++;
      $display("FAIL result: got %h required %h", bus.result, want);
    end
    tick();
    if (!keep_high) bus.finish = 1'b0;
    total_checks++;
    if (rv_cnt - rv0 != 1 || bus.result !== want) begin
      bad++;
      $display("FAIL result_pulse: pulses=%0d result=%h required 1 pulse, %h held", rv_cnt - rv0, bus.result, want);
    end
  endtask

  task automatic test_reset();
    reset                 = 1'b0;
    bus.start             = 1'b0;
    bus.total             = '0;
    bus.a_base            = '0;
    bus.b_base            = '0;
    bus.I_am_ready        = 1'b0;
    bus.finish            = 1'b0;
    bus.dot_product_input = '0;
    repeat (3) tick();
    check_all_zero("reset_state");
    reset = 1'b1;
    tick();
    total_checks++;
    if ({bus.dp_reset, bus.busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release: dp_reset,busy=%b required 00", {bus.dp_reset, bus.busy});
    end
  endtask

  task automatic test_single();
    int s0;
    s0 = strobe_cnt;
    start_job(32'd8, 10'h000, 10'h020);
    serve_pkg(1, 1'b0, 1'b0);
    finish_job(4, 32'h3F80_0000, 1'b0);
    total_checks++;
    if (strobe_cnt - s0 != 1) begin
      bad++;
      $display("FAIL single_strobes: got %0d required 1", strobe_cnt - s0);
    end
  endtask

  // Latencies alternate 1 and 3; the slow packages also get a ready pulse in the strobe cycle, which must be ignored.
  task automatic test_multi();
    int s0;
    s0 = strobe_cnt;
    start_job(32'd32, 10'h000, 10'h100);
    for (int k = 0; k < 4; k++) serve_pkg((k % 2 == 1) ? 3 : 1, k % 2 == 1, 1'b0);
    finish_job(2, 32'h4120_0000, 1'b0);
    total_checks++;
    if (strobe_cnt - s0 != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL multi_strobes: got %0d left=%0d required 4 left=0", strobe_cnt - s0, exp_q.size());
    end
  endtask

  task automatic test_bad_total();
    int rd0, e0;
    logic [31:0] bad_totals[2];
    bad_totals[0] = 32'd12;
    bad_totals[1] = 32'd0;
    rd0 = rd_cnt;
    e0  = err_cnt;
    for (int i = 0; i < 2; i++) begin
      bus.total = bad_totals[i];
      bus.start = 1'b1;
      tick();
      total_checks++;
      if ({bus.error, bus.busy} !== 2'b10) begin
        bad++;
        $display("FAIL bad_total_%0d: error,busy=%b required 10", bad_totals[i], {bus.error, bus.busy});
      end
      tick();
      total_checks++;
      if ({bus.error, bus.busy} !== 2'b00) begin
        bad++;
        $display("FAIL bad_total_after_%0d: error,busy=%b required 00", bad_totals[i], {bus.error, bus.busy});
      end
    end
    total_checks++;
    if (rd_cnt != rd0 || err_cnt - e0 != 2) begin
      bad++;
      $display("FAIL bad_total_counts: reads=%0d errors=%0d required 0 and 2", rd_cnt - rd0, err_cnt - e0);
    end
  endtask

  task automatic test_wrap();
    start_job(32'd16, 10'h3FF, 10'h3F0);
    serve_pkg(1, 1'b0, 1'b0);
    serve_pkg(2, 1'b0, 1'b0);
    finish_job(1, 32'h0000_1234, 1'b0);
  endtask

  // finish stays high from the previous job, so the next job sees no edge and must time out.
  task automatic test_timeout();
    int rv0, n;
    start_job(32'd8, 10'h005, 10'h006);
    serve_pkg(1, 1'b0, 1'b0);
    finish_job(2, 32'hCAFE_F00D, 1'b1);
    rv0 = rv_cnt;
    start_job(32'd8, 10'h007, 10'h008);
    serve_pkg(1, 1'b0, 1'b0);
    n = 0;
    while (!bus.error && n < 400) begin
      tick();
      n++;
    end
    // 256 cycles in WAIT_FINISH, one cycle to enter it, and the registered error pulse.
    total_checks++;
    if (n != tmo + 1) begin
      bad++;
      $display("FAIL timeout_latency: error after %0d cycles required %0d", n, tmo + 1);
    end
    total_checks++;
    if ({bus.busy, bus.dp_reset, bus.result} !== {2'b01, 32'hCAFE_F00D} || rv_cnt != rv0) begin
      bad++;
      $display("FAIL timeout_state: busy=%b dp_reset=%b result=%h captures=%0d required 0 1 cafef00d 0",
               bus.busy, bus.dp_reset, bus.result, rv_cnt - rv0);
    end
    tick();
    bus.finish = 1'b0;
    total_checks++;
    if ({bus.dp_reset, bus.error} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_after: dp_reset,error=%b required 00", {bus.dp_reset, bus.error});
    end
  endtask

  task automatic test_reset_abort();
    int rv0, e0;
    rv0 = rv_cnt;
    e0  = err_cnt;
    start_job(32'd32, 10'h010, 10'h030);
    serve_pkg(1, 1'b0, 1'b0);
    serve_pkg(0, 1'b0, 1'b1);
    tick();
    check_all_zero("abort_state");
    exp_q.delete();
    reset = 1'b1;
    tick();
    total_checks++;
    if (bus.dp_reset !== 1'b0 || rv_cnt != rv0 || err_cnt != e0) begin
      bad++;
      $display("FAIL abort_release: dp_reset=%b captures=%0d errors=%0d required 0 0 0",
               bus.dp_reset, rv_cnt - rv0, err_cnt - e0);
    end
    start_job(32'd8, 10'h040, 10'h050);
    serve_pkg(1, 1'b0, 1'b0);
    finish_job(3, 32'h4000_0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_bad_total();
    test_wrap();
    test_timeout();
    test_reset_abort();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total_checks, bad);
    $finish;
  end
endmodule
